lif_neuron_array: RTL and testbench
===================================

// Module: lif_neuron_array
// PURPOSE
//   N_CH parallel leaky integrate-and-fire neurons sharing threshold, leak and refractory settings.
//   Each neuron advances one timestep per 'step' strobe; each emits a one-cycle spike.
//   Multi-channel, parametrised successor of the single LIF neuron in the tt_um top level.
//   Instantiated inside the tt_um wrapper; pins are mapped by the wrapper.
// PARAMETERS
//   N_CH       4   number of neurons (channels)
//   V_W        8   membrane potential width (unsigned)
//   IN_W       8   per-channel input current width (unsigned, IN_W <= V_W)
//   LS_W       4   leak_shift width
//   R_W        4   refractory counter width
//   RESET_MODE 0   post-spike reset: 0 = potential to zero, 1 = subtract threshold
//   CNT_W      8   spike counter width (used only with LIF_SPIKE_CNT_EN)
// PORTS
//   clk        in   1           clock
//   rst_n      in   1           asynchronous active-low reset
//   ena        in   1           block enable; step ignored while low
//   step       in   1           timestep strobe, one-cycle pulse
//   cur_in     in   N_CH*IN_W   input currents, channel k at [k*IN_W +: IN_W]
//   threshold  in   V_W         firing threshold
//   leak_shift in   LS_W        leak = v >> leak_shift
//   refrac     in   R_W         refractory length in timesteps
//   mon_sel    in   $clog2(N_CH) channel to monitor
//   spike      out  N_CH        per-channel spike pulse
//   v_mon      out  V_W         registered potential of channel mon_sel
//   clr_cnt    in   1           [LIF_SPIKE_CNT_EN] clear all spike counters
//   spike_cnt  out  CNT_W       [LIF_SPIKE_CNT_EN] spike count of channel mon_sel
// BEHAVIOUR
//   Reset: all v = 0, refractory counters = 0, state INTEGRATE; spike = 0, v_mon = 0, spike_cnt = 0.
//   Timestep: a step is accepted only when step = 1 and ena = 1. Inputs are sampled in the step cycle.
//   Per-channel states:
//   - INTEGRATE:
//     - v_next = v - (v >> leak_shift) + cur_in, computed at V_W+1 bits and saturated to 2^V_W-1.
//     - leak_shift = 0 gives full leak (v_next = cur_in); leak_shift >= V_W gives no leak.
//     - If v_next >= threshold: spike[k] = 1 in the cycle after step, for exactly one cycle.
//       - v becomes 0 (RESET_MODE 0) or v_next - threshold (RESET_MODE 1).
//       - If refrac != 0: ref counter is loaded with refrac and the channel enters REFRACTORY.
//     - Otherwise v becomes v_next.
//   - REFRACTORY: each accepted step ignores cur_in, holds v, decrements the counter, never spikes.
//     The channel returns to INTEGRATE on the step that brings the counter to 0.
//   threshold = 0: the channel spikes on every accepted INTEGRATE step.
//   Changing threshold, leak or refrac between steps affects only later steps; no state is flushed.
//   Back-to-back steps (every cycle) are legal; the design has full throughput with 1-cycle latency.
//   v_mon: registered every cycle from v[mon_sel], 1-cycle latency, regardless of ena.
//   mon_sel >= N_CH: v_mon = 0.
//   rst_n low mid-operation clears everything immediately (asynchronous), including a spike in flight.
// CONFIGURATION
//   LIF_SPIKE_CNT_EN defined:
//   - Each channel gets a CNT_W counter, incremented on each of its spikes, saturating at 2^CNT_W-1.
//   - clr_cnt zeroes all counters next cycle; if clr_cnt coincides with a spike, the count is 0.
//   - spike_cnt is registered from counter[mon_sel] with 1-cycle latency.
//   LIF_SPIKE_CNT_EN undefined: no counters; clr_cnt and spike_cnt ports are absent.
// STRUCTURE
//   Package lif_pkg:
//   - state enum {INTEGRATE, REFRACTORY}
//   - RESET_ZERO / RESET_SUB constants
//   - saturating-add function
//   Sub-module lif_cell: one neuron (v, state, ref counter, spike register).
//   lif_neuron_array: generate loop of N_CH lif_cell, plus the monitor mux and optional counters.
// TESTING (defaults; leak_shift = 15 means no leak unless stated)
//   1 thr=100, ch0 cur=30, 4 steps -> spike[0] only after step 4; v_mon 30,60,90, then 0.
//     RESET_MODE=1 build: v ends at 20.
//   2 leak_shift=1, thr=100, cur=64 for one step then 0 -> v_mon 64,32,16,8; no spikes.
//   3 refrac=2, thr=100, cur=120 every step -> spikes on steps 1 and 4 only; v=0 during steps 2-3.
//   4 thr=255, cur=200 -> step1 v=200; step2 saturates to 255 and spikes; step every cycle stays 1-cycle spaced.
//   5 ena=0 with step pulses -> v unchanged; rst_n low while v=50 -> v_mon 0 and spike 0 without a clk edge.
//   6 LIF_SPIKE_CNT_EN: 3 spikes on ch2, mon_sel=2 -> spike_cnt=3; clr_cnt -> 0; 300 spikes -> 255.

Source files
------------

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types, reset-mode constants and saturating add for the LIF neuron array
package lif_pkg;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } lif_state_t;

  localparam int RESET_ZERO = 0;
  localparam int RESET_SUB  = 1;

  // Unsigned a + b clamped to 2^w-1; operands are zero-extended by the caller.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [31:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_cell.sv
// rtl/lif_cell.sv - one leaky integrate-and-fire neuron: potential, refractory counter, spike register
module lif_cell
  import lif_pkg::*;
#(
  parameter int V_W        = 8,
  parameter int IN_W       = 8,
  parameter int LS_W       = 4,
  parameter int R_W        = 4,
  parameter int RESET_MODE = RESET_ZERO
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            accept,
  input  logic [IN_W-1:0] cur,
  input  logic [V_W-1:0]  threshold,
  input  logic [LS_W-1:0] leak_shift,
  input  logic [R_W-1:0]  refrac,
  output logic [V_W-1:0]  v,
  output logic            spike
);

  lif_state_t     state, state_next;
  logic [R_W-1:0] ref_cnt, ref_next;
  logic [V_W-1:0] v_next, leaked, v_sum;
  logic           spike_next;

  // Shifts of V_W or more leave nothing to subtract, giving the no-leak case for free.
  assign leaked = v - (v >> leak_shift);
  assign v_sum  = V_W'(sat_add(32'(leaked), 32'(cur), V_W));

  always_comb begin
    state_next = state;
    v_next     = v;
    ref_next   = ref_cnt;
    spike_next = 1'b0;
    if (accept) begin
      case (state)
        INTEGRATE: begin
          if (v_sum >= threshold) begin
            spike_next = 1'b1;
            v_next     = (RESET_MODE == RESET_SUB) ? (v_sum - threshold) : '0;
            if (refrac != '0) begin
              ref_next   = refrac;
              state_next = REFRACTORY;
            end
          end else begin
            v_next = v_sum;
          end
        end
        REFRACTORY: begin
          ref_next = ref_cnt - R_W'(1);
          if (ref_cnt == R_W'(1)) state_next = INTEGRATE;
        end
        default: state_next = INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INTEGRATE;
      v       <= '0;
      ref_cnt <= '0;
      spike   <= 1'b0;
    end else begin
      state   <= state_next;
      v       <= v_next;
      ref_cnt <= ref_next;
      spike   <= spike_next;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - N_CH LIF neurons with potential monitor; LIF_SPIKE_CNT_EN adds spike counters
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int V_W        = 8,
  parameter int IN_W       = 8,
  parameter int LS_W       = 4,
  parameter int R_W        = 4,
  parameter int RESET_MODE = RESET_ZERO,
  parameter int CNT_W      = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ena,
  input  logic                                  step,
  input  logic [N_CH*IN_W-1:0]                  cur_in,
  input  logic [V_W-1:0]                        threshold,
  input  logic [LS_W-1:0]                       leak_shift,
  input  logic [R_W-1:0]                        refrac,
  input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] mon_sel,
  output logic [N_CH-1:0]                       spike,
  output logic [V_W-1:0]                        v_mon
`ifdef LIF_SPIKE_CNT_EN
  ,
  input  logic                                  clr_cnt,
  output logic [CNT_W-1:0]                      spike_cnt
`endif
);

  logic           accept;
  logic [V_W-1:0] v_arr [N_CH];
  logic           mon_valid;

  assign accept    = step & ena;
  assign mon_valid = 32'(mon_sel) < N_CH;

  for (genvar k = 0; k < N_CH; k++) begin : g_cell
    lif_cell #(
      .V_W        (V_W),
      .IN_W       (IN_W),
      .LS_W       (LS_W),
      .R_W        (R_W),
      .RESET_MODE (RESET_MODE)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .accept     (accept),
      .cur        (cur_in[k*IN_W +: IN_W]),
      .threshold  (threshold),
      .leak_shift (leak_shift),
      .refrac     (refrac),
      .v          (v_arr[k]),
      .spike      (spike[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_mon <= '0;
    else        v_mon <= mon_valid ? v_arr[mon_sel] : '0;
  end

`ifdef LIF_SPIKE_CNT_EN
  logic [CNT_W-1:0] cnt [N_CH];

  // Clear wins over a coincident spike so a cleared counter always reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
      spike_cnt <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (clr_cnt)                       cnt[k] <= '0;
        else if (spike[k] && cnt[k] != '1) cnt[k] <= cnt[k] + CNT_W'(1);
      end
      spike_cnt <= mon_valid ? cnt[mon_sel] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - scoreboard bench for lif_neuron_array (counter checks with LIF_SPIKE_CNT_EN)
module tb_lif_neuron_array;

  localparam int N_CH  = 4;
  localparam int V_W   = 8;
  localparam int IN_W  = 8;
  localparam int LS_W  = 4;
  localparam int R_W   = 4;
  localparam int RM    = 0;
  localparam int CNT_W = 8;
  localparam int V_MAX = (1 << V_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n, ena, step;
  logic [N_CH*IN_W-1:0] cur_in;
  logic [V_W-1:0]       threshold;
  logic [LS_W-1:0]      leak_shift;
  logic [R_W-1:0]       refrac;
  logic [1:0]           mon_sel;
  logic [N_CH-1:0]      spike;
  logic [V_W-1:0]       v_mon;
`ifdef LIF_SPIKE_CNT_EN
  logic                 clr_cnt;
  logic [CNT_W-1:0]     spike_cnt;
`endif

  lif_neuron_array #(
    .N_CH(N_CH), .V_W(V_W), .IN_W(IN_W), .LS_W(LS_W), .R_W(R_W),
    .RESET_MODE(RM), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .step       (step),
    .cur_in     (cur_in),
    .threshold  (threshold),
    .leak_shift (leak_shift),
    .refrac     (refrac),
    .mon_sel    (mon_sel),
    .spike      (spike),
    .v_mon      (v_mon)
`ifdef LIF_SPIKE_CNT_EN
    ,
    .clr_cnt    (clr_cnt),
    .spike_cnt  (spike_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Staged inputs, applied by tick() just after a falling edge.
  int s_cur [N_CH];
  int s_thr, s_ls, s_rf, s_mon;
  bit s_ena, s_clr;

  // Reference neuron state.
  int mv [N_CH];
  int mref [N_CH];
  bit mrefr [N_CH];
  int spk_seen [N_CH];

  typedef struct {
    int spk;
    int vm;
  } exp_t;
  exp_t sb[$];

  task automatic model_clear;
    for (int k = 0; k < N_CH; k++) begin
      mv[k] = 0; mref[k] = 0; mrefr[k] = 1'b0; spk_seen[k] = 0;
    end
    sb.delete();
  endtask

  task automatic tick(input bit stp);
    exp_t e;
    int   lk, s;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("spike", int'(spike), e.spk);
      check("v_mon", int'(v_mon), e.vm);
      for (int k = 0; k < N_CH; k++) spk_seen[k] += int'(spike[k]);
    end
    ena        = s_ena;
    step       = stp;
    threshold  = V_W'(s_thr);
    leak_shift = LS_W'(s_ls);
    refrac     = R_W'(s_rf);
    mon_sel    = 2'(s_mon);
    for (int k = 0; k < N_CH; k++) cur_in[k*IN_W +: IN_W] = IN_W'(s_cur[k]);
`ifdef LIF_SPIKE_CNT_EN
    clr_cnt = s_clr;
`endif
    // v_mon captured at the coming edge shows the potential from before that edge.
    e.vm  = mv[s_mon];
    e.spk = 0;
    if (stp && s_ena) begin
      for (int k = 0; k < N_CH; k++) begin
        if (mrefr[k]) begin
          mref[k]--;
          if (mref[k] == 0) mrefr[k] = 1'b0;
        end else begin
          lk = (s_ls >= V_W) ? 0 : (mv[k] >> s_ls);
          s  = mv[k] - lk + s_cur[k];
          if (s > V_MAX) s = V_MAX;
          if (s >= s_thr) begin
            e.spk |= (1 << k);
            mv[k] = (RM == 1) ? s - s_thr : 0;
            if (s_rf != 0) begin
              mrefr[k] = 1'b1;
              mref[k]  = s_rf;
            end
          end else begin
            mv[k] = s;
          end
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic reset_all;
    rst_n = 1'b0;
    step  = 1'b0;
    ena   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    check("rst_spike", int'(spike), 0);
    check("rst_v_mon", int'(v_mon), 0);
  endtask

  task automatic defaults;
    for (int k = 0; k < N_CH; k++) s_cur[k] = 0;
    s_thr = 100; s_ls = 15; s_rf = 0; s_mon = 0; s_ena = 1'b1; s_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  initial begin
    cur_in = '0; threshold = '0; leak_shift = '0; refrac = '0; mon_sel = '0;
`ifdef LIF_SPIKE_CNT_EN
    clr_cnt = 1'b0;
`endif
    defaults();
    reset_all();

    // Integrate to threshold: 30,60,90 then spike and clear on step 4.
    s_cur[0] = 30;
    for (int i = 0; i < 4; i++) begin tick(1'b1); tick(1'b0); end
    idle(2);
    check("t1_spikes", spk_seen[0], 1);
    check("t1_v_mon", int'(v_mon), 0);

    // Leak by half each step, no input after the first.
    reset_all(); defaults();
    s_ls = 1; s_cur[0] = 64;
    tick(1'b1);
    s_cur[0] = 0;
    for (int i = 0; i < 3; i++) tick(1'b1);
    idle(2);
    check("t2_v_mon", int'(v_mon), 8);
    check("t2_spikes", spk_seen[0], 0);

    // Refractory period of two steps.
    reset_all(); defaults();
    s_rf = 2; s_cur[0] = 120;
    for (int i = 0; i < 5; i++) tick(1'b1);
    idle(2);
    check("t3_spikes", spk_seen[0], 2);

    // Saturation at full scale with back-to-back steps, other channels active too.
    reset_all(); defaults();
    s_thr = 255; s_cur[0] = 200; s_cur[1] = 255; s_cur[2] = 90; s_cur[3] = 1; s_mon = 2;
    for (int i = 0; i < 6; i++) tick(1'b1);
    idle(2);
    check("t4_spikes0", spk_seen[0], 3);
    check("t4_spikes1", spk_seen[1], 6);

    // Steps ignored while disabled, then asynchronous reset with a spike in flight.
    reset_all(); defaults();
    s_cur[0] = 50;
    tick(1'b1);
    s_ena = 1'b0; s_cur[0] = 40;
    for (int i = 0; i < 3; i++) tick(1'b1);
    s_ena = 1'b1; s_cur[0] = 0; s_cur[1] = 100;
    tick(1'b0);
    tick(1'b1);
    @(posedge clk);
    #2;
    check("t5_spike_before", int'(spike), 2);
    check("t5_v_mon_before", int'(v_mon), 50);
    rst_n = 1'b0;
    #1;
    check("t5_async_spike", int'(spike), 0);
    check("t5_async_v_mon", int'(v_mon), 0);
    reset_all(); defaults();

`ifdef LIF_SPIKE_CNT_EN
    // Spike counters: count, clear, saturate.
    s_thr = 0; s_mon = 2;
    for (int i = 0; i < 3; i++) tick(1'b1);
    idle(3);
    check("t6_cnt3", int'(spike_cnt), 3);
    s_clr = 1'b1; tick(1'b0); s_clr = 1'b0;
    idle(3);
    check("t6_clr", int'(spike_cnt), 0);
    for (int i = 0; i < 300; i++) tick(1'b1);
    idle(3);
    check("t6_sat", int'(spike_cnt), 255);
    reset_all(); defaults();
`endif

    // Random mix of parameters, enables and step patterns.
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < N_CH; k++) s_cur[k] = int'($urandom_range(0, 120));
      if ($urandom_range(0, 7) == 0) s_thr = int'($urandom_range(0, 255));
      s_ls  = int'($urandom_range(0, 9));
      s_rf  = int'($urandom_range(0, 3));
      s_mon = int'($urandom_range(0, N_CH - 1));
      s_ena = ($urandom_range(0, 5) != 0);
      tick($urandom_range(0, 2) != 0);
    end
    idle(2);
    check("sb_drained", sb.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
